pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 `clk`  input  1  Single clock; all state changes on the rising edge.
REQ-003 `reset`  input  1  Asynchronous, active-low reset (0 = reset).
REQ-004 `ld_use_hazard`  input  1  ID instruction reads the destination of a load currently in EX.
REQ-005 `branch_taken`  input  1  Taken branch/jump resolved in EX this cycle.
REQ-006 `icache_miss`  input  1  IF fetch missed this cycle.
REQ-007 `icache_ready`  input  1  Outstanding instruction fill completes this cycle.
REQ-008 `dcache_miss`  input  1  M-stage access missed this cycle.
REQ-009 `dcache_ready`  input  1  Outstanding data fill completes this cycle.
REQ-010 `cnt_clear`  input  1  Synchronous clear of `stall_cycles`.
REQ-011 `pc_write`, `f_d_write`, `d_e_write`, `e_m_write`, `m_wb_write`  output  1 each  Write enables for the PC and the F/D, D/E, E/M and M/WB pipeline registers.
REQ-012 `f_d_flush`, `d_e_flush`  output  1 each  Insert a bubble (zero control bits) into F/D or D/E on the next edge.
REQ-013 `state`  output  2  Current FSM state.
REQ-014 `stall_cycles`  output  16  Saturating count of stall cycles.

Function
REQ-015 The FSM SHALL have four states: RUN=00, ISTALL=01, DSTALL=10, DISTALL=11.
REQ-016 All outputs except `state` and `stall_cycles` SHALL be combinational (Mealy) from the current state and inputs; there is no added latency.
REQ-017 RUN, no events: all five write enables 1, both flushes 0.
REQ-018 ld_use_hazard alone: `pc_write`=0, `f_d_write`=0, `d_e_flush`=1, all other enables 1; this lasts one cycle and does not change state.
REQ-019 branch_taken: `f_d_flush`=1, `d_e_flush`=1, all enables 1; it has priority over ld_use_hazard.
REQ-020 Freeze output set: all five enables 0, both flushes 0.
REQ-021 In RUN, dcache_miss SHALL produce freeze outputs that cycle, overriding the branch and hazard rules.
REQ-022 In RUN, icache_miss without dcache_miss SHALL produce the RUN outputs with `pc_write`=0 and `f_d_write`=0, and `f_d_flush`=1 unless branch_taken.
REQ-023 In ISTALL, outputs SHALL be as in RUN with `pc_write`=0, `f_d_write`=0 and `f_d_flush`=1, with two exceptions:
  - icache_ready=1: full RUN outputs.
  - branch_taken=1: `pc_write`=1 (redirect) plus both flushes.
REQ-024 In DSTALL and DISTALL with dcache_ready=0, the block SHALL produce freeze outputs.
REQ-025 In DSTALL with dcache_ready=1, the block SHALL produce the RUN outputs (pipeline advances).
REQ-026 In DISTALL with dcache_ready=1, the block SHALL produce the ISTALL outputs.
REQ-027 Transitions from RUN:
  - dcache_miss & icache_miss -> DISTALL.
  - dcache_miss -> DSTALL.
  - icache_miss -> ISTALL.
  - otherwise stay in RUN.
REQ-028 Transitions from ISTALL:
  - dcache_miss & !icache_ready -> DISTALL.
  - dcache_miss & icache_ready -> DSTALL.
  - icache_ready -> RUN.
  - otherwise stay in ISTALL.
REQ-029 Transitions from DSTALL: dcache_ready -> RUN, otherwise stay; icache_miss SHALL be ignored in DSTALL.
REQ-030 Transitions from DISTALL:
  - both ready -> RUN.
  - dcache_ready only -> ISTALL.
  - icache_ready only -> DSTALL.
  - otherwise stay.
REQ-031 ready inputs asserted in a state not waiting on them SHALL be ignored.
REQ-032 `stall_cycles` SHALL increment by 1 on every edge where the state is not RUN.
  - It saturates at 0xFFFF.
  - `cnt_clear` has priority over increment; when both are asserted, the result is 0.

Reset
REQ-033 When `reset`=0, asynchronously: state=RUN, `stall_cycles`=0.
REQ-034 While `reset`=0, all write enables and flushes SHALL be forced to 0 regardless of inputs.
REQ-035 Reset asserted mid-stall SHALL abandon the stall; after release the block is in RUN and pending ready pulses are not remembered.
REQ-036 The first edge after reset deasserts SHALL behave as RUN.

Verification
REQ-037 Load-use: RUN, ld_use_hazard=1 for 1 cycle -> `pc_write`=0, `f_d_write`=0, `d_e_flush`=1, `m_wb_write`=1, state stays 00.
REQ-038 Dcache miss: dcache_miss=1 at cycle 0, dcache_ready=1 at cycle 4 ->
  - freeze outputs in cycles 0-3;
  - all enables 1 in cycle 4;
  - state 10 during cycles 1-4, then 00;
  - `stall_cycles`=4.
REQ-039 Simultaneous misses: dcache_miss=icache_miss=1 -> DISTALL; icache_ready at +2 -> DSTALL; dcache_ready at +4 -> RUN; no ready pulse is lost.
REQ-040 Branch priority: branch_taken=1 with ld_use_hazard=1 in RUN -> both flushes 1, `pc_write`=1. Branch in ISTALL -> `pc_write`=1 and state stays 01.
REQ-041 Saturation and clear: preload the count at 0xFFFE, then 3 stall cycles -> 0xFFFF. Then cnt_clear=1 during a stall -> 0.
REQ-042 Async reset: assert `reset`=0 between clock edges while in DISTALL -> state 00, count 0, and all enables 0 immediately (before the next edge).

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline stall controller bus: hazard/cache event inputs toward the
// controller, and write-enable/flush/status outputs back to the pipeline.
interface pipe_stall_ctrl_if;
  logic        ld_use_hazard;
  logic        branch_taken;
  logic        icache_miss;
  logic        icache_ready;
  logic        dcache_miss;
  logic        dcache_ready;
  logic        cnt_clear;
  logic        pc_write;
  logic        f_d_write;
  logic        d_e_write;
  logic        e_m_write;
  logic        m_wb_write;
  logic        f_d_flush;
  logic        d_e_flush;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  // Pipeline side: raises events, consumes the control outputs
  modport master (
    output ld_use_hazard, branch_taken, icache_miss, icache_ready,
           dcache_miss, dcache_ready, cnt_clear,
    input  pc_write, f_d_write, d_e_write, e_m_write, m_wb_write,
           f_d_flush, d_e_flush, state, stall_cycles
  );

  // Controller side
  modport slave (
    input  ld_use_hazard, branch_taken, icache_miss, icache_ready,
           dcache_miss, dcache_ready, cnt_clear,
    output pc_write, f_d_write, d_e_write, e_m_write, m_wb_write,
           f_d_flush, d_e_flush, state, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Five-stage pipeline stall/flush controller.
// Tracks outstanding instruction and data cache fills in a four-state FSM and
// produces Mealy write enables and flushes for the PC and pipeline registers.
// Control vectors are packed as {pc, f_d, d_e, e_m, m_wb, f_d_flush, d_e_flush}.
module pipe_stall_ctrl (
  input  logic             clk,
  input  logic             reset,
  pipe_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    ISTALL  = 2'b01,
    DSTALL  = 2'b10,
    DISTALL = 2'b11
  } state_t;

  localparam logic [6:0] CTL_FREEZE = 7'b0000000;
  localparam logic [6:0] CTL_NORMAL = 7'b1111100;
  localparam logic [6:0] CTL_BRANCH = 7'b1111111;
  localparam logic [6:0] CTL_LDUSE  = 7'b0011101;
  localparam logic [6:0] CTL_IREDIR = 7'b1011111;

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [6:0]  ctl;

  // Normal flow: a taken branch squashes both younger stages and wins over
  // a load-use hazard, which holds PC/F-D and bubbles D/E for one cycle.
  function automatic logic [6:0] runCtl(input logic br, input logic haz);
    if (br)
      return CTL_BRANCH;
    else if (haz)
      return CTL_LDUSE;
    else
      return CTL_NORMAL;
  endfunction

  // Front end waiting on a fetch: hold PC and F/D, feed a bubble into F/D.
  function automatic logic [6:0] fetchHold(input logic [6:0] c);
    return {2'b00, c[4:2], 1'b1, c[0]};
  endfunction

  // Outputs while an instruction fill is outstanding; a taken branch may
  // still redirect the PC even though fetch is stalled.
  function automatic logic [6:0] istallCtl(input logic br, input logic haz,
                                           input logic iready);
    if (iready)
      return runCtl(br, haz);
    else if (br)
      return CTL_IREDIR;
    else
      return fetchHold(runCtl(br, haz));
  endfunction

  // Next-state selection and Mealy control outputs
  always_comb begin
    state_d = state_q;
    ctl     = CTL_FREEZE;
    case (state_q)
      RUN: begin
        if (bus.dcache_miss) begin
          ctl     = CTL_FREEZE;
          state_d = bus.icache_miss ? DISTALL : DSTALL;
        end else if (bus.icache_miss) begin
          ctl     = fetchHold(runCtl(bus.branch_taken, bus.ld_use_hazard));
          state_d = ISTALL;
        end else begin
          ctl     = runCtl(bus.branch_taken, bus.ld_use_hazard);
        end
      end
      ISTALL: begin
        ctl = istallCtl(bus.branch_taken, bus.ld_use_hazard, bus.icache_ready);
        if (bus.dcache_miss)
          state_d = bus.icache_ready ? DSTALL : DISTALL;
        else if (bus.icache_ready)
          state_d = RUN;
      end
      DSTALL: begin
        if (bus.dcache_ready) begin
          ctl     = runCtl(bus.branch_taken, bus.ld_use_hazard);
          state_d = RUN;
        end
      end
      DISTALL: begin
        if (bus.dcache_ready) begin
          ctl     = istallCtl(bus.branch_taken, bus.ld_use_hazard, bus.icache_ready);
          state_d = bus.icache_ready ? RUN : ISTALL;
        end else if (bus.icache_ready) begin
          state_d = DSTALL;
        end
      end
      default: begin
        state_d = RUN;
        ctl     = CTL_FREEZE;
      end
    endcase
  end

  // Stall counter: clear wins, otherwise count non-RUN cycles and saturate
  always_comb begin
    count_d = count_q;
    if (bus.cnt_clear)
      count_d = 16'h0000;
    else if (state_q != RUN && count_q != 16'hFFFF)
      count_d = count_q + 16'd1;
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign {bus.pc_write, bus.f_d_write, bus.d_e_write, bus.e_m_write,
          bus.m_wb_write, bus.f_d_flush, bus.d_e_flush} = reset ? ctl : CTL_FREEZE;
  assign bus.state        = state_q;
  assign bus.stall_cycles = count_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Testbench for pipe_stall_ctrl: directed scenarios plus random traffic,
// checked against a model that tracks "instruction fill pending" and
// "data fill pending" flags rather than named FSM states.
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic reset;

  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Stimulus vector bits: {ld, br, imiss, iready, dmiss, dready, clr}
  localparam logic [6:0] LD  = 7'b1000000;
  localparam logic [6:0] BR  = 7'b0100000;
  localparam logic [6:0] IM  = 7'b0010000;
  localparam logic [6:0] IR  = 7'b0001000;
  localparam logic [6:0] DM  = 7'b0000100;
  localparam logic [6:0] DR  = 7'b0000010;
  localparam logic [6:0] CLR = 7'b0000001;

  int errors = 0;
  int checks = 0;

  logic        mdWait;
  logic        miWait;
  int unsigned mCount;

  task automatic applyStimulus(input logic [6:0] v);
    bus.ld_use_hazard = v[6];
    bus.branch_taken  = v[5];
    bus.icache_miss   = v[4];
    bus.icache_ready  = v[3];
    bus.dcache_miss   = v[2];
    bus.dcache_ready  = v[1];
    bus.cnt_clear     = v[0];
  endtask

  task automatic modelReset();
    mdWait = 1'b0;
    miWait = 1'b0;
    mCount = 0;
  endtask

  // Expected {pc, f_d, d_e, e_m, m_wb, f_d_flush, d_e_flush}
  function automatic logic [6:0] modelCtl();
    logic running, frozen, fetchBlocked;
    logic pc, fd, de, em, mwb, fdf, def;
    running      = !mdWait && !miWait;
    frozen       = (running && bus.dcache_miss) || (mdWait && !bus.dcache_ready);
    fetchBlocked = running ? bus.icache_miss : (miWait && !bus.icache_ready);
    if (!reset || frozen) return 7'b0000000;
    pc = 1'b1; fd = 1'b1; de = 1'b1; em = 1'b1; mwb = 1'b1; fdf = 1'b0; def = 1'b0;
    if (bus.branch_taken) begin
      fdf = 1'b1;
      def = 1'b1;
    end else if (bus.ld_use_hazard) begin
      pc  = 1'b0;
      fd  = 1'b0;
      def = 1'b1;
    end
    if (fetchBlocked) begin
      fd  = 1'b0;
      fdf = 1'b1;
      pc  = !running && bus.branch_taken;
    end
    return {pc, fd, de, em, mwb, fdf, def};
  endfunction

  task automatic modelUpdate();
    logic running, newD, newI;
    if (!reset) begin
      modelReset();
    end else begin
      running = !mdWait && !miWait;
      newD = mdWait ? !bus.dcache_ready : bus.dcache_miss;
      newI = miWait ? !bus.icache_ready : (running && bus.icache_miss);
      if (bus.cnt_clear)
        mCount = 0;
      else if (!running && mCount < 32'hFFFF)
        mCount = mCount + 1;
      mdWait = newD;
      miWait = newI;
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [6:0] got, exp;
    got = {bus.pc_write, bus.f_d_write, bus.d_e_write, bus.e_m_write,
           bus.m_wb_write, bus.f_d_flush, bus.d_e_flush};
    exp = modelCtl();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s ctl observed=%b expected=%b", tag, got, exp);
    end
    checks++;
    assert (bus.state === {mdWait, miWait}) else begin
      errors++;
      $error("[TB] FAIL %s state observed=%b expected=%b", tag, bus.state, {mdWait, miWait});
    end
    checks++;
    assert (bus.stall_cycles === mCount[15:0]) else begin
      errors++;
      $error("[TB] FAIL %s count observed=%h expected=%h", tag, bus.stall_cycles, mCount[15:0]);
    end
  endtask

  // One clock: drive inputs, check combinational outputs mid-cycle, advance
  task automatic cycle(input logic [6:0] v, input string tag, input bit doCheck);
    applyStimulus(v);
    @(negedge clk);
    if (doCheck) checkOutput(tag);
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic checkConst(input string tag, input logic [15:0] got,
                            input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    logic [6:0] v;

    // Reset held: outputs forced low even with events present
    reset = 1'b0;
    modelReset();
    applyStimulus(LD | BR | IM | DM);
    #1;
    checkOutput("reset_forced");
    cycle(LD | BR | DR | IR, "reset_hold", 1'b1);
    reset = 1'b1;

    // First edge after release behaves as RUN
    cycle(7'b0, "first_run", 1'b1);
    cycle(7'b0, "run_idle", 1'b1);

    // Load-use bubble, then branch priority over hazard
    cycle(LD, "load_use", 1'b1);
    checkConst("load_use_state", {14'b0, bus.state}, 16'h0000);
    cycle(LD | BR, "branch_over_hazard", 1'b1);
    cycle(BR, "branch_only", 1'b1);

    // Data miss, ready four cycles later
    cycle(DM, "dmiss_c0", 1'b1);
    cycle(7'b0, "dstall_c1", 1'b1);
    cycle(7'b0, "dstall_c2", 1'b1);
    cycle(7'b0, "dstall_c3", 1'b1);
    cycle(DR, "dstall_ready", 1'b1);
    checkConst("dstall_count", bus.stall_cycles, 16'd4);
    cycle(7'b0, "after_dstall", 1'b1);

    // Simultaneous misses, staggered fills
    cycle(DM | IM, "dimiss", 1'b1);
    cycle(7'b0, "distall_wait", 1'b1);
    cycle(IR, "distall_iready", 1'b1);
    cycle(7'b0, "dstall_wait", 1'b1);
    cycle(DR, "dstall_dready", 1'b1);
    cycle(7'b0, "after_distall", 1'b1);
    checkConst("distall_state", {14'b0, bus.state}, 16'h0000);

    // Branch redirect during instruction stall
    cycle(IM | LD, "imiss_hazard", 1'b1);
    cycle(BR, "istall_branch", 1'b1);
    cycle(LD, "istall_hazard", 1'b1);
    cycle(DM, "istall_dmiss", 1'b1);
    cycle(7'b0, "distall_from_istall", 1'b1);
    cycle(DR | BR, "distall_dready_branch", 1'b1);
    cycle(IR | LD, "istall_iready", 1'b1);
    cycle(7'b0, "run_again", 1'b1);

    // Irrelevant ready/miss inputs while in DSTALL and RUN
    cycle(IR | DR, "run_stray_ready", 1'b1);
    cycle(DM | BR, "dmiss_branch", 1'b1);
    cycle(IM | IR, "dstall_ignore_i", 1'b1);
    cycle(DR | IM, "dstall_exit", 1'b1);
    cycle(7'b0, "post_dstall", 1'b1);

    // Saturation: clear, then stall until the count nears the top
    cycle(CLR, "clear_run", 1'b1);
    cycle(DM, "sat_enter", 1'b1);
    for (int i = 0; i < 70000 && mCount < 32'hFFFE; i++)
      cycle(7'b0, "sat_fill", 1'b0);
    checkConst("sat_fffe", bus.stall_cycles, 16'hFFFE);
    cycle(7'b0, "sat_1", 1'b1);
    cycle(7'b0, "sat_2", 1'b1);
    cycle(7'b0, "sat_3", 1'b1);
    checkConst("sat_ffff", bus.stall_cycles, 16'hFFFF);
    cycle(CLR, "sat_clear", 1'b1);
    checkConst("sat_cleared", bus.stall_cycles, 16'h0000);
    cycle(DR, "sat_exit", 1'b1);
    cycle(7'b0, "sat_run", 1'b1);

    // Asynchronous reset in the middle of a double stall
    cycle(DM | IM, "pre_reset_distall", 1'b1);
    applyStimulus(BR);
    @(negedge clk);
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset");
    @(posedge clk);
    modelUpdate();
    #1;
    cycle(DR | IR | LD, "reset_ready_pulse", 1'b1);
    reset = 1'b1;
    cycle(7'b0, "post_reset", 1'b1);
    cycle(DR | IR, "post_reset_stray", 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      v[6] = ($urandom_range(3) == 0);
      v[5] = ($urandom_range(7) == 0);
      v[4] = ($urandom_range(5) == 0);
      v[3] = ($urandom_range(3) == 0);
      v[2] = ($urandom_range(7) == 0);
      v[1] = ($urandom_range(3) == 0);
      v[0] = ($urandom_range(31) == 0);
      cycle(v, "random", 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
